// File: rtl/barrel_shift.sv
// ---------------------------------------------------------------------------
// barrel_shift -- registered logarithmic barrel rotator
//
// Rotates the data word `a` by `amt` bit positions, right when `direction`
// is 1 and left when it is 0. The result is a pure circular rotate, so no
// bits are lost and nothing is shifted in.
//
// Rotate right is y[i] = a[(i + amt) mod WIDTH].
// Rotate left is y[i] = a[(i - amt) mod WIDTH].
//
// Only one rotate-right network is built. A left rotate bit-reverses the
// word on the way in and again on the way out, which mirrors the right
// network into a left one.
//
// The network has AMT_W stages. Stage k rotates right by 2**k when
// amt[k] = 1. The stages are grouped into two parts:
//   * the "front" part holds the 1- and 2-position stages;
//   * the "back" part holds the remaining stages.
//
// Parameters
//   WIDTH  data width; a power of two from 2 to 64
//   AMT_W  shift-amount width; must equal log2(WIDTH)
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   synchronous active-high reset; clears y and all
//                   pipeline registers
//   a          in   [WIDTH-1:0]  data word to rotate
//   amt        in   [AMT_W-1:0]  rotate distance, 0..WIDTH-1
//   direction  in   1 = rotate right (toward LSB), 0 = rotate left
//   y          out  [WIDTH-1:0]  registered rotate result
//
// Configuration macro: BARREL_SHIFT_PIPE_EN
//   Undefined (default): latency is 1 cycle.
//   Defined: the front-part output is registered, together with
//   direction and amt, before the back part. Latency becomes 2 cycles
//   and a new result is still produced every cycle.
// ---------------------------------------------------------------------------
module barrel_shift #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a,
    input  logic [AMT_W-1:0] amt,
    input  logic             direction,
    output logic [WIDTH-1:0] y
);

    // Number of stages in the front part (the 1- and 2-position stages).
    // For narrow words this covers every stage.
    localparam int SPLIT = (AMT_W < 2) ? AMT_W : 2;

    // Mirror a word end-for-end. This turns the right network into a left one.
    function automatic logic [WIDTH-1:0] bit_rev(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        for (int i = 0; i < WIDTH; i++) begin
            r[i] = v[WIDTH-1-i];
        end
        return r;
    endfunction

    logic [WIDTH-1:0] front_s [0:SPLIT];
    logic [WIDTH-1:0] back_s  [SPLIT:AMT_W];
    logic [WIDTH-1:0] mid_s;
    logic [AMT_W-1:0] amt_back_s;
    logic             dir_back_s;
    logic [AMT_W-1:0] amt_stage_s;
    logic [WIDTH-1:0] y_d;
    logic [WIDTH-1:0] y_q;

    // Stage select bits. Front stages take amt directly; back stages take
    // the copy of amt that travels with the data (delayed when the
    // pipeline register is present).
    always_comb begin
        amt_stage_s = amt_back_s;
        for (int k = 0; k < SPLIT; k++) begin
            amt_stage_s[k] = amt[k];
        end
    end

    // Left rotates enter the right network mirrored.
    assign front_s[0] = direction ? a : bit_rev(a);

    genvar k;
    generate
        for (k = 0; k < SPLIT; k++) begin : g_front
            localparam int SH = 1 << k;
            // A rotate right by SH moves the low SH bits to the top.
            assign front_s[k+1] = amt_stage_s[k]
                ? {front_s[k][SH-1:0], front_s[k][WIDTH-1:SH]}
                : front_s[k];
        end

        for (k = SPLIT; k < AMT_W; k++) begin : g_back
            localparam int SH = 1 << k;
            assign back_s[k+1] = amt_stage_s[k]
                ? {back_s[k][SH-1:0], back_s[k][WIDTH-1:SH]}
                : back_s[k];
        end
    endgenerate

`ifdef BARREL_SHIFT_PIPE_EN
    logic [WIDTH-1:0] mid_q;
    logic [AMT_W-1:0] amt_mid_q;
    logic             dir_mid_q;

    // Register the front-part result. Direction and amt are registered with
    // it so the back part and the output un-mirror act on the same
    // transaction.
    always_ff @(posedge clk) begin
        if (reset) begin
            mid_q     <= '0;
            amt_mid_q <= '0;
            dir_mid_q <= 1'b0;
        end else begin
            mid_q     <= front_s[SPLIT];
            amt_mid_q <= amt;
            dir_mid_q <= direction;
        end
    end

    assign mid_s      = mid_q;
    assign amt_back_s = amt_mid_q;
    assign dir_back_s = dir_mid_q;
`else
    assign mid_s      = front_s[SPLIT];
    assign amt_back_s = amt;
    assign dir_back_s = direction;
`endif

    assign back_s[SPLIT] = mid_s;

    // Undo the input mirror for left rotates.
    assign y_d = dir_back_s ? back_s[AMT_W] : bit_rev(back_s[AMT_W]);

    // Output register. Inputs sampled during reset are discarded.
    always_ff @(posedge clk) begin
        if (reset) begin
            y_q <= '0;
        end else begin
            y_q <= y_d;
        end
    end

    assign y = y_q;

endmodule

// File: tb/tb_barrel_shift.sv
module tb_barrel_shift;

`ifdef BARREL_SHIFT_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic       clk;
    logic       reset;
    logic [7:0] a;
    logic [2:0] amt;
    logic       direction;
    logic [7:0] y;

    int checks   = 0;
    int failures = 0;

    // Expected outputs, in the order the DUT will produce them.
    logic [7:0] exp_q [$];

    barrel_shift #(.WIDTH(8), .AMT_W(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .a         (a),
        .amt       (amt),
        .direction (direction),
        .y         (y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference rotate, written directly from the index definitions.
    function automatic logic [7:0] rot_model(input logic [7:0] av, input logic [2:0] n, input logic dir);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            if (dir) r[i] = av[(i + int'(n)) % 8];
            else     r[i] = av[(i - int'(n) + 8) % 8];
        end
        return r;
    endfunction

    // Present one vector for one edge.
    //   1. Compare y just after the edge.
    //   2. Scramble the inputs.
    //   3. Confirm y holds its value between edges.
    task automatic cycle(input string tag, input logic [7:0] av, input logic [2:0] amv,
                         input logic dv, input logic rv, input logic [7:0] ev);
        logic [7:0] want;
        a = av; amt = amv; direction = dv; reset = rv;
        @(posedge clk);
        #1;
        if (rv) begin
            exp_q.delete();
            for (int i = 0; i < LAT; i++) exp_q.push_back(8'h00);
        end else begin
            exp_q.push_back(ev);
        end
        want = exp_q.pop_front();
        checks++;
        assert (y === want) else begin
            failures++;
            $error("FAIL %s: y=%h expected=%h", tag, y, want);
        end
        a = 8'($urandom); amt = 3'($urandom); direction = 1'($urandom);
        #3;
        checks++;
        assert (y === want) else begin
            failures++;
            $error("FAIL %s_hold: y=%h expected=%h", tag, y, want);
        end
    endtask

    // Drive one vector whose expected result comes from the reference model.
    task automatic mcycle(input string tag, input logic [7:0] av, input logic [2:0] amv,
                          input logic dv);
        cycle(tag, av, amv, dv, 1'b0, rot_model(av, amv, dv));
    endtask

    initial begin
        logic [7:0] ra;
        logic [2:0] rn;
        logic       rd;

        a = 8'h00; amt = 3'd0; direction = 1'b0; reset = 1'b1;

        // Reset state.
        cycle("reset0", 8'hFF, 3'd3, 1'b1, 1'b1, 8'h00);
        cycle("reset1", 8'hA5, 3'd5, 1'b0, 1'b1, 8'h00);

        // Directed results for a = 0x79.
        cycle("amt0_r", 8'h79, 3'd0, 1'b1, 1'b0, 8'h79);
        cycle("amt0_l", 8'h79, 3'd0, 1'b0, 1'b0, 8'h79);
        cycle("amt1_r", 8'h79, 3'd1, 1'b1, 1'b0, 8'hBC);
        cycle("amt1_l", 8'h79, 3'd1, 1'b0, 1'b0, 8'hF2);
        cycle("amt2_r", 8'h79, 3'd2, 1'b1, 1'b0, 8'h5E);
        cycle("amt2_l", 8'h79, 3'd2, 1'b0, 1'b0, 8'hE5);
        cycle("amt4_r", 8'h79, 3'd4, 1'b1, 1'b0, 8'h97);
        cycle("amt4_l", 8'h79, 3'd4, 1'b0, 1'b0, 8'h97);
        cycle("amt7_r", 8'h79, 3'd7, 1'b1, 1'b0, 8'hF2);
        cycle("amt7_l", 8'h79, 3'd7, 1'b0, 1'b0, 8'hBC);

        // Right by n versus left by 8-n, on random words.
        for (int n = 1; n < 8; n++) begin
            ra = 8'($urandom);
            mcycle("dual_r", ra, 3'(n), 1'b1);
            mcycle("dual_l", ra, 3'(8 - n), 1'b0);
        end

        // Back-to-back random stream.
        for (int i = 0; i < 10; i++) begin
            ra = 8'($urandom); rn = 3'($urandom); rd = 1'($urandom);
            mcycle("stream_a", ra, rn, rd);
        end

        // One-cycle reset mid-stream with live inputs; in-flight data must vanish.
        cycle("mid_reset", 8'hC3, 3'd1, 1'b1, 1'b1, 8'h00);

        for (int i = 0; i < 10; i++) begin
            ra = 8'($urandom); rn = 3'($urandom); rd = 1'($urandom);
            mcycle("stream_b", ra, rn, rd);
        end

        // Flush the pipeline with all-ones and single-bit words.
        mcycle("ones", 8'hFF, 3'd5, 1'b0);
        mcycle("onebit_r", 8'h01, 3'd1, 1'b1);
        mcycle("onebit_l", 8'h80, 3'd1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/barrel_shift.md
BARREL_SHIFT -- requirements
Module: barrel_shift

Interface
REQ-001 Parameter WIDTH, default 8: data width in bits; the module SHALL support any power of two from 2 to 64.
REQ-002 Parameter AMT_W, default 3: shift-amount width; the module SHALL require AMT_W = log2(WIDTH).
REQ-003 Port clk, input, 1: the single clock; all state SHALL update on its rising edge only.
REQ-004 Port reset, input, 1: synchronous active-high reset, sampled on the rising edge of clk.
REQ-005 Port a, input, WIDTH: data word to rotate.
REQ-006 Port amt, input, AMT_W: rotate distance, 0 to WIDTH-1 bit positions.
REQ-007 Port direction, input, 1: 1 = rotate right (toward LSB), 0 = rotate left (toward MSB).
REQ-008 Port y, output, WIDTH: registered rotate result.

Function
REQ-009 The block SHALL perform a circular rotate; no bit is lost and no fill value is inserted.
REQ-010 Rotate right SHALL be defined as: y[i] = a[(i + amt) mod WIDTH].
REQ-011 Rotate left SHALL be defined as: y[i] = a[(i - amt) mod WIDTH].
REQ-012 The implementation SHALL be a logarithmic barrel: AMT_W mux stages, where stage k rotates by 2^k when amt[k] = 1.
REQ-013 The left rotate SHALL reuse the right-rotate network by bit-reversing the input and output, or by using an equivalent mirrored network; results SHALL match REQ-010 and REQ-011 exactly.
REQ-014 amt = 0 SHALL give y = a for both directions.
REQ-015 Rotate right by n SHALL equal rotate left by WIDTH-n for every n from 1 to WIDTH-1.
REQ-016 Rotate by WIDTH/2 SHALL give the same result for both directions.
REQ-017 Without PIPE_EN, a, amt and direction SHALL be sampled together on a rising edge of clk, and y SHALL show the result after that edge (latency 1 cycle, one new result per cycle).
REQ-018 A change to any input between edges SHALL NOT affect y until the next rising edge.
REQ-019 There SHALL be no handshake: every cycle is a valid transaction.

Reset
REQ-020 On a rising edge of clk with reset = 1, y and all internal pipeline registers SHALL become 0.
REQ-021 Inputs presented on an edge where reset = 1 SHALL be discarded.
REQ-022 An operation in flight when reset asserts SHALL be lost and SHALL NOT appear on y after reset deasserts.
REQ-023 The first result after reset deasserts SHALL appear one latency period after the first edge that samples reset = 0.

Configuration
REQ-024 Macro BARREL_SHIFT_PIPE_EN: when defined, the block SHALL register the stage-1 output (after the 1- and 2-position stages) before the final stage; latency SHALL be 2 cycles, with throughput still one result per cycle.
REQ-025 With BARREL_SHIFT_PIPE_EN defined, direction and the remaining amt bits SHALL be pipelined alongside the data so each result is self-consistent.
REQ-026 When BARREL_SHIFT_PIPE_EN is undefined, latency SHALL be 1 cycle per REQ-017, and ports and functional results SHALL be identical to the defined case.

Verification
All scenarios use WIDTH = 8, a = 0x79, macro undefined unless stated.
REQ-027 amt = 0: direction = 1 -> y = 0x79 and direction = 0 -> y = 0x79, each one cycle after sampling.
REQ-028 amt = 1: direction = 1 -> y = 0xBC; direction = 0 -> y = 0xF2.
REQ-029 amt = 2: direction = 1 -> y = 0x5E; direction = 0 -> y = 0xE5. amt = 4: y = 0x97 for both directions.
REQ-030 amt = 7: direction = 1 -> y = 0xF2; direction = 0 -> y = 0xBC (matches the amt = 1 results in the opposite direction).
REQ-031 Back-to-back stimulus: a new vector applied every cycle, then reset asserted for 1 cycle mid-stream -> y = 0x00 after the reset edge, no pre-reset result reappears, and correct results resume.
REQ-032 With BARREL_SHIFT_PIPE_EN defined, rerun REQ-027 to REQ-031 -> same values, each delayed by exactly 2 cycles.
